// File: rtl/keystroke_voice_alloc_pkg.sv
// Shared definitions for the keystroke voice allocator.
//   - default key and voice counts
//   - key_width(): index width for a count of keys or voices (at least 1 bit)
//   - lowest_set(): index of the lowest set bit of a mask (0 when the mask is empty)
package keystroke_voice_pkg;

    localparam int DEF_NUM_KEYS   = 12;
    localparam int DEF_NUM_VOICES = 4;

    function automatic int key_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int lowest_set(input logic [31:0] mask);
        int idx;
        idx = 0;
        // Walk downwards so the last hit is the lowest index.
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keystroke_voice_alloc_if.sv
// Bus between the keystroke source and the voice allocator.
//   keystroke     raw key levels, 1 = held (source -> allocator)
//   voice_active  1 = voice v sounding
//   voice_key     key index of voice v at [v*KEY_W +: KEY_W]
//   voice_start   one-cycle pulse when voice v is (re)allocated
//   overflow      sticky; a request was dropped or a voice was stolen
// master = keystroke source side, slave = allocator side.
interface keystroke_voice_alloc_if #(
    parameter int NUM_KEYS   = keystroke_voice_pkg::DEF_NUM_KEYS,
    parameter int NUM_VOICES = keystroke_voice_pkg::DEF_NUM_VOICES
);
    localparam int KEY_W = keystroke_voice_pkg::key_width(NUM_KEYS);

    logic [NUM_KEYS-1:0]         keystroke;
    logic [NUM_VOICES-1:0]       voice_active;
    logic [NUM_VOICES*KEY_W-1:0] voice_key;
    logic [NUM_VOICES-1:0]       voice_start;
    logic                        overflow;

    modport master (output keystroke, input voice_active, voice_key, voice_start, overflow);
    modport slave  (input keystroke, output voice_active, voice_key, voice_start, overflow);

endinterface

// File: rtl/keystroke_voice_alloc_lru.sv
// Allocation-age tracker for the voice bank.
//   clk_raw, rst    clock and asynchronous active-high reset
//   alloc           a voice is being (re)allocated this cycle
//   alloc_voice     index of that voice
//   voice_active    current active mask
//   victim          active voice with the largest age, lowest index on ties
//   free_mask       1 = voice v is idle
module voice_lru
    import keystroke_voice_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int VIDX_W     = key_width(NUM_VOICES)
) (
    input  logic                  clk_raw,
    input  logic                  rst,
    input  logic                  alloc,
    input  logic [VIDX_W-1:0]     alloc_voice,
    input  logic [NUM_VOICES-1:0] voice_active,
    output logic [VIDX_W-1:0]     victim,
    output logic [NUM_VOICES-1:0] free_mask
);
    localparam int AGE_W = key_width(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    logic [AGE_W-1:0] age [NUM_VOICES];
    logic [AGE_W-1:0] best_age;

    // Ages only move on allocation events, so they rank voices by allocation order.
    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            // NOTE: age is a small flop array, not a RAM, so it can take the async reset.
            for (int v = 0; v < NUM_VOICES; v++) age[v] <= '0;
        end else if (alloc) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (VIDX_W'(v) == alloc_voice)
                    age[v] <= '0;
                else if (voice_active[v] && age[v] != AGE_MAX)
                    age[v] <= age[v] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        victim   = '0;
        best_age = '0;
        // Strict '>' keeps the lowest index on ties.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && age[v] > best_age) begin
                victim   = VIDX_W'(v);
                best_age = age[v];
            end
        end
    end

    assign free_mask = ~voice_active;

endmodule

// File: rtl/keystroke_voice_alloc.sv
// Polyphony scheduler: synchronises raw key levels and maps held keys onto
// NUM_VOICES tone generators, stealing the oldest voice when full (STEAL=1)
// or dropping the request (STEAL=0).
//   clk_raw   system clock, rising edge
//   rst       asynchronous active-high reset
//   bus       slave side of keystroke_voice_alloc_if (keystroke in, voice_* / overflow out)
module keystroke_voice_alloc
    import keystroke_voice_pkg::*;
#(
    parameter int NUM_KEYS   = DEF_NUM_KEYS,
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter bit STEAL      = 1'b1
) (
    input  logic                    clk_raw,
    input  logic                    rst,
    keystroke_voice_alloc_if.slave  bus
);
    localparam int KEY_W  = key_width(NUM_KEYS);
    localparam int VIDX_W = key_width(NUM_VOICES);

    typedef logic [KEY_W-1:0]  key_t;
    typedef logic [VIDX_W-1:0] vidx_t;

    logic [NUM_KEYS-1:0]   sync1, ks;
    logic [NUM_KEYS-1:0]   key_assigned, key_stolen;
    logic [NUM_KEYS-1:0]   assigned_nxt, stolen_nxt;
    key_t                  scan_p;
    logic [NUM_VOICES-1:0] voice_active, voice_start, release_mask, free_mask;
    key_t                  voice_key [NUM_VOICES];
    logic                  overflow;

    logic        request, full, take_free, take_steal, alloc, set_overflow;
    vidx_t       alloc_voice, victim;
    logic [31:0] free32;

    voice_lru #(.NUM_VOICES(NUM_VOICES), .VIDX_W(VIDX_W)) u_lru (
        .clk_raw      (clk_raw),
        .rst          (rst),
        .alloc        (alloc),
        .alloc_voice  (alloc_voice),
        .voice_active (voice_active),
        .victim       (victim),
        .free_mask    (free_mask)
    );

    always_comb begin
        release_mask = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            release_mask[v] = voice_active[v] && !ks[voice_key[v]];
    end

    // A voice releasing this cycle still counts as busy, so 'full' uses the
    // registered active mask. If the chosen victim is itself releasing, the
    // release wins and the key is simply retried on the next scan pass.
    assign request      = ks[scan_p] && !key_assigned[scan_p] && !key_stolen[scan_p];
    assign full         = (free_mask == '0);
    assign take_free    = request && !full;
    assign take_steal   = request && full && STEAL && !release_mask[victim];
    assign alloc        = take_free || take_steal;
    assign set_overflow = take_steal || (request && full && !STEAL);
    assign free32       = 32'(free_mask);
    assign alloc_voice  = take_free ? vidx_t'(lowest_set(free32)) : victim;

    always_comb begin
        assigned_nxt = key_assigned;
        stolen_nxt   = key_stolen & ks;
        for (int v = 0; v < NUM_VOICES; v++)
            if (release_mask[v]) assigned_nxt[voice_key[v]] = 1'b0;
        // The displaced key stays blocked until it is released.
        if (take_steal) begin
            assigned_nxt[voice_key[victim]] = 1'b0;
            stolen_nxt[voice_key[victim]]   = 1'b1;
        end
        if (alloc) assigned_nxt[scan_p] = 1'b1;
    end

    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            ks           <= '0;
            key_assigned <= '0;
            key_stolen   <= '0;
            scan_p       <= '0;
            voice_active <= '0;
            voice_start  <= '0;
            overflow     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) voice_key[v] <= '0;
        end else begin
            sync1        <= bus.keystroke;
            ks           <= sync1;
            key_assigned <= assigned_nxt;
            key_stolen   <= stolen_nxt;
            scan_p       <= (scan_p == key_t'(NUM_KEYS - 1)) ? '0 : scan_p + KEY_W'(1);
            // NOTE: later non-blocking assignments win, so the default clear
            // below is overridden bit-wise by the allocation that follows.
            voice_start  <= '0;
            for (int v = 0; v < NUM_VOICES; v++)
                if (release_mask[v]) voice_active[v] <= 1'b0;
            if (alloc) begin
                voice_key[alloc_voice]    <= scan_p;
                voice_active[alloc_voice] <= 1'b1;
                voice_start[alloc_voice]  <= 1'b1;
            end
            if (set_overflow) overflow <= 1'b1;
        end
    end

    assign bus.voice_active = voice_active;
    assign bus.voice_start  = voice_start;
    assign bus.overflow     = overflow;

    always_comb begin
        bus.voice_key = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            bus.voice_key[v*KEY_W +: KEY_W] = voice_key[v];
    end

endmodule

// File: tb/tb_keystroke_voice_alloc.sv
module tb_keystroke_voice_alloc;

    logic clk_raw = 1'b0;
    logic rst     = 1'b1;

    always #5 clk_raw = ~clk_raw;

    keystroke_voice_alloc_if bus_s ();
    keystroke_voice_alloc_if bus_d ();

    keystroke_voice_alloc #(.NUM_KEYS(12), .NUM_VOICES(4), .STEAL(1'b1)) dut_s (
        .clk_raw (clk_raw),
        .rst     (rst),
        .bus     (bus_s)
    );

    keystroke_voice_alloc #(.NUM_KEYS(12), .NUM_VOICES(4), .STEAL(1'b0)) dut_d (
        .clk_raw (clk_raw),
        .rst     (rst),
        .bus     (bus_d)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Independent model of the scan pointer: rising edges since reset released.
    int unsigned cnt;
    always @(posedge clk_raw or posedge rst) begin
        if (rst) cnt <= 0;
        else     cnt <= cnt + 1;
    end

    // voice_start monitor for the STEAL=1 instance.
    int         start_s [4];
    int         wide_s = 0;
    logic [3:0] prev_s = '0;
    always @(negedge clk_raw or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) start_s[i] <= 0;
            prev_s <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus_s.voice_start[i]) start_s[i] <= start_s[i] + 1;
            if ((prev_s & bus_s.voice_start) != 4'b0) wide_s <= wide_s + 1;
            prev_s <= bus_s.voice_start;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample 1 ns after the falling edge, well away from the rising edge.
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_raw);
        #1;
    endtask

    // Return 1 ns after the rising edge such that a level driven now is
    // evaluated by the scan exactly when the pointer sits on key k.
    task automatic align(input int k);
        for (int i = 0; i < 24; i++) begin
            @(posedge clk_raw);
            #1;
            if (cnt % 12 == (k + 10) % 12) return;
        end
        n_checks++;
        n_err++;
        $error("FAIL align_timeout: observed=none expected=key %0d", k);
    endtask

    initial begin
        bus_s.keystroke = '0;
        bus_d.keystroke = '0;

        // Reset state
        wait_neg(3);
        check("rst_active",   bus_s.voice_active, 4'b0000);
        check("rst_key",      bus_s.voice_key,    16'h0000);
        check("rst_start",    bus_s.voice_start,  4'b0000);
        check("rst_overflow", bus_s.overflow,     1'b0);
        check("rst_active_d", bus_d.voice_active, 4'b0000);
        rst = 1'b0;

        // 1: keys 0 and 4 -> voices 0 and 1
        align(0);
        bus_s.keystroke = 12'h011;
        wait_neg(4);
        check("t1_active0",  bus_s.voice_active, 4'b0001);
        check("t1_start0",   bus_s.voice_start,  4'b0001);
        check("t1_key0",     bus_s.voice_key[3:0], 4'h0);
        wait_neg(4);
        check("t1_active01", bus_s.voice_active, 4'b0011);
        check("t1_start1",   bus_s.voice_start,  4'b0010);
        check("t1_key",      bus_s.voice_key[7:0], 8'h40);
        check("t1_cnt0",     start_s[0], 1);
        check("t1_cnt1",     start_s[1], 1);
        check("t1_overflow", bus_s.overflow, 1'b0);

        // 2: move to keys 1 and 5; release lands exactly 3 cycles later
        bus_s.keystroke = 12'h022;
        wait_neg(2);
        check("t2_not_yet", bus_s.voice_active, 4'b0011);
        wait_neg(1);
        check("t2_release", bus_s.voice_active, 4'b0000);
        wait_neg(6);
        check("t2_key1",    bus_s.voice_key[3:0], 4'h1);
        check("t2_active0", bus_s.voice_active, 4'b0001);
        wait_neg(4);
        check("t2_active",  bus_s.voice_active, 4'b0011);
        check("t2_key",     bus_s.voice_key[7:0], 8'h51);
        check("t2_cnt0",    start_s[0], 2);
        check("t2_cnt1",    start_s[1], 2);
        check("t2_overflow", bus_s.overflow, 1'b0);

        // 3: STEAL=1, full bank, key 9 steals the oldest voice
        rst = 1'b1;
        bus_s.keystroke = '0;
        wait_neg(2);
        rst = 1'b0;
        align(0);
        bus_s.keystroke = 12'h00F;
        wait_neg(7);
        check("t3_full",     bus_s.voice_active, 4'b1111);
        check("t3_keys",     bus_s.voice_key, 16'h3210);
        check("t3_ovf0",     bus_s.overflow, 1'b0);
        bus_s.keystroke = 12'h20F;
        wait_neg(15);
        check("t3_steal",    bus_s.voice_key, 16'h3219);
        check("t3_ovf1",     bus_s.overflow, 1'b1);
        check("t3_cnt0",     start_s[0], 2);
        wait_neg(15);
        check("t3_no_retake", bus_s.voice_key, 16'h3219);
        check("t3_cnt0_hold", start_s[0], 2);
        bus_s.keystroke = 12'h206;
        wait_neg(4);
        check("t3_rel3",     bus_s.voice_active, 4'b0111);
        bus_s.keystroke = 12'h207;
        wait_neg(15);
        check("t3_repress",  bus_s.voice_active, 4'b1111);
        check("t3_keys2",    bus_s.voice_key, 16'h0219);

        // 4: STEAL=0, request dropped, then served after a release
        align(0);
        bus_d.keystroke = 12'h00F;
        wait_neg(7);
        check("t4_keys",     bus_d.voice_key, 16'h3210);
        check("t4_ovf0",     bus_d.overflow, 1'b0);
        bus_d.keystroke = 12'h20F;
        wait_neg(15);
        check("t4_unchanged", bus_d.voice_key, 16'h3210);
        check("t4_active",   bus_d.voice_active, 4'b1111);
        check("t4_ovf1",     bus_d.overflow, 1'b1);
        bus_d.keystroke = 12'h20B;
        wait_neg(15);
        check("t4_retry",    bus_d.voice_key, 16'h3910);
        check("t4_active2",  bus_d.voice_active, 4'b1111);

        // 6: async reset silences all voices before the next edge
        rst = 1'b1;
        #1;
        check("t6_async_active", bus_s.voice_active, 4'b0000);
        check("t6_async_key",    bus_s.voice_key, 16'h0000);
        check("t6_async_ovf",    bus_s.overflow, 1'b0);
        bus_s.keystroke = '0;
        bus_d.keystroke = '0;
        wait_neg(2);
        rst = 1'b0;
        align(0);
        bus_s.keystroke = 12'h088;
        wait_neg(11);
        check("t6_active",  bus_s.voice_active, 4'b0011);
        check("t6_keys",    bus_s.voice_key[7:0], 8'h73);

        // 5: one-cycle press, then a sub-cycle glitch
        bus_s.keystroke = '0;
        wait_neg(5);
        check("t5_idle",    bus_s.voice_active, 4'b0000);
        align(3);
        bus_s.keystroke = 12'h008;
        @(posedge clk_raw);
        #1;
        bus_s.keystroke = '0;
        wait_neg(3);
        check("t5_alloc",   bus_s.voice_active, 4'b0001);
        check("t5_pulse",   bus_s.voice_start,  4'b0001);
        check("t5_key",     bus_s.voice_key[3:0], 4'h3);
        wait_neg(1);
        check("t5_release", bus_s.voice_active, 4'b0000);
        check("t5_pulse_end", bus_s.voice_start, 4'b0000);
        check("t5_cnt0",    start_s[0], 2);
        bus_s.keystroke = 12'h008;
        #2;
        bus_s.keystroke = '0;
        wait_neg(20);
        check("t5_glitch_active", bus_s.voice_active, 4'b0000);
        check("t5_glitch_cnt",    start_s[0], 2);
        check("t5_start_width",   wide_s, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
